// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream engine.
// Holds the control FSM state encoding, the skid buffer depth and a helper
// that sizes the burst counters from the configured burst length.
package fifo_rd_pkg;

    // Control FSM states of the read engine.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } rd_state_t;

    // Number of words the skid can hold. This covers the one-cycle FIFO read
    // latency at full throughput.
    localparam int SKID_DEPTH = 2;

    // Width of a counter that runs modulo burst_len (at least one bit).
    function automatic int cnt_width(input int burst_len);
        return (burst_len <= 2) ? 1 : $clog2(burst_len);
    endfunction

endpackage : fifo_rd_pkg

// File: rtl/fifo_rd_skid.sv
// Two-entry, order-preserving skid buffer for the FIFO read engine.
// Words enter on i_push and leave from the head on i_pop.
// The head is always presented on o_head, and o_occ reports the fill level (0..2).
// The caller never pushes into a full buffer and never pops an empty one.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [1:0]            o_occ
);

    localparam logic [1:0] FULL_OCC = 2'(SKID_DEPTH);

    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [1:0]            r_occ;

    // Shift words through head/tail while keeping arrival order.
    always_ff @(posedge clk) begin
        // NOTE: every register in a clocked block uses <=, so each one samples
        // the values from before the edge, whatever order they appear in.
        if (rst) begin
            // NOTE: the data entries are reset along with the occupancy
            // because the head drives the stream data port, which must read
            // zero out of reset.
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (i_push) begin
                        r_head <= i_push_data;
                        r_occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (i_push && i_pop) begin
                        // The old head leaves and the new word takes its place.
                        r_head <= i_push_data;
                    end else if (i_push) begin
                        r_tail <= i_push_data;
                        r_occ  <= FULL_OCC;
                    end else if (i_pop) begin
                        r_occ  <= 2'd0;
                    end
                end
                default: begin
                    if (i_pop) begin
                        r_head <= r_tail;
                        if (i_push) begin
                            r_tail <= i_push_data;
                        end else begin
                            r_occ  <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign o_head = r_head;
    assign o_occ  = r_occ;

endmodule : fifo_rd_skid

// File: rtl/fifo_stream_reader.sv
// Read-side engine for the 8x8 synchronous FIFO.
// The engine drains the FIFO through fifo_re/fifo_r_data/fifo_empty and
// absorbs the one-cycle read latency in a 2-entry skid buffer.
// Words are presented on a valid/ready stream, with m_last marking the final
// word of every BURST_LEN-word burst.
// Optional feature: define FIFO_RD_STATS_EN to add a 16-bit word_count output
// that counts accepted stream words.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    output logic                  fifo_re,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [15:0]           word_count
`endif
);

    localparam int             CW       = cnt_width(BURST_LEN);
    localparam logic [CW-1:0]  LAST_IDX = CW'(BURST_LEN - 1);

    rd_state_t             r_state;
    logic [CW-1:0]         r_req_cnt;
    logic [CW-1:0]         r_beat_cnt;
    logic                  r_inflight;

    logic [CW-1:0]         w_req_cnt_nxt;
    logic [1:0]            w_occ;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_valid;
    logic                  w_pop;
    logic [2:0]            w_demand;
    logic                  w_fifo_re;

    // Issue a read only when the skid is guaranteed room for the returning word.
    always_comb begin
        // NOTE: each signal gets a default before any condition, so no path
        // leaves it unassigned and no latch is inferred.
        w_valid       = (w_occ != 2'd0);
        w_pop         = w_valid && m_ready;
        // Words held plus words on their way, minus the one leaving this cycle.
        w_demand      = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);
        w_fifo_re     = !rst && (r_state != IDLE) && !fifo_empty &&
                        (w_demand < 3'(SKID_DEPTH));
        w_req_cnt_nxt = r_req_cnt;
        if (w_fifo_re) begin
            w_req_cnt_nxt = (r_req_cnt == LAST_IDX) ? '0 : r_req_cnt + CW'(1);
        end
    end

    // Control FSM. A stop request finishes the open burst before going idle.
    // The burst-boundary test uses the count after this cycle's read, so a
    // read issued in the same cycle as the stop is included in the burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        r_state <= (w_req_cnt_nxt == '0) ? IDLE : FINISH;
                    end
                end
                FINISH: begin
                    if (w_req_cnt_nxt == '0) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Track issued reads, accepted beats and the word in flight from the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_cnt  <= '0;
            r_beat_cnt <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_req_cnt  <= w_req_cnt_nxt;
            r_inflight <= w_fifo_re;
            if (w_pop) begin
                r_beat_cnt <= (r_beat_cnt == LAST_IDX) ? '0 : r_beat_cnt + CW'(1);
            end
        end
    end

    // Returning FIFO words are captured in every state, so a stop never loses data.
    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (fifo_r_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_occ       (w_occ)
    );

    assign fifo_re = w_fifo_re;
    assign m_valid = w_valid;
    assign m_data  = w_head;
    assign m_last  = w_valid && (r_beat_cnt == LAST_IDX);
    assign busy    = (r_state != IDLE) || r_inflight || w_valid;

`ifdef FIFO_RD_STATS_EN
    logic [15:0] r_word_count;

    // Count accepted stream words; the counter wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_count <= 16'd0;
        end else if (w_pop) begin
            r_word_count <= r_word_count + 16'd1;
        end
    end

    assign word_count = r_word_count;
`endif

endmodule : fifo_stream_reader

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader (BURST_LEN = 4).
// A small FIFO model with one-cycle read latency feeds the DUT.
// Cycle tables cover streaming and backpressure, and hand-written sequences
// cover stop mid-burst, empty stalls and reset mid-operation.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_r_data = '0;
    logic          fifo_re;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic          busy;
`ifdef FIFO_RD_STATS_EN
    logic [15:0]   word_count;
`endif

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_r_data (fifo_r_data),
        .fifo_re     (fifo_re),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .busy        (busy)
`ifdef FIFO_RD_STATS_EN
        ,
        .word_count  (word_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // FIFO model: a read returns data one cycle later, and writes appear on the next edge.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] wr_q[$];
    int            rd_count = 0;

    always @(posedge clk) begin
        if (fifo_re && fifo_q.size() != 0) begin
            fifo_r_data <= fifo_q.pop_front();
            rd_count    <= rd_count + 1;
        end
        while (wr_q.size() != 0) begin
            fifo_q.push_back(wr_q.pop_front());
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Stream monitor and protocol watchers, sampled mid-cycle.
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } beat_t;

    beat_t log_q[$];
    int    cyc        = 0;
    int    underruns  = 0;
    int    re_in_rst  = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (fifo_re && fifo_empty) underruns <= underruns + 1;
        if (fifo_re && rst)        re_in_rst <= re_in_rst + 1;
        if (!rst && m_valid && m_ready) begin
            log_q.push_back('{data: m_data, last: m_last, cyc: cyc});
        end
    end

    // Per-cycle vector: inputs driven for the cycle, outputs expected mid-cycle.
    typedef struct {
        logic          en;
        logic          rdy;
        logic          exp_re;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic          exp_last;
        logic          exp_busy;
    } vec_t;

    vec_t t1[12];
    vec_t t2[17];

    function automatic vec_t mk(input logic en, input logic rdy, input logic re,
                                input logic v, input logic [DW-1:0] d,
                                input logic l, input logic b);
        vec_t r;
        r.en = en; r.rdy = rdy; r.exp_re = re; r.exp_valid = v;
        r.exp_data = d; r.exp_last = l; r.exp_busy = b;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) wr_q.push_back(base + DW'(i));
    endtask

    task automatic check_vec(input string tag, input int i, input vec_t v);
        check($sformatf("%s[%0d].fifo_re", tag, i), 32'(fifo_re), 32'(v.exp_re));
        check($sformatf("%s[%0d].m_valid", tag, i), 32'(m_valid), 32'(v.exp_valid));
        if (v.exp_valid) begin
            check($sformatf("%s[%0d].m_data", tag, i), 32'(m_data), 32'(v.exp_data));
        end
        check($sformatf("%s[%0d].m_last", tag, i), 32'(m_last), 32'(v.exp_last));
        check($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(v.exp_busy));
    endtask

    task automatic wait_log(input string name, input int n, input int budget);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check({name, ".wait"}, 32'(log_q.size() >= n), 32'd1);
    endtask

    task automatic check_log(input string name, input logic [DW-1:0] base, input int n);
        check({name, ".count"}, 32'(log_q.size()), 32'(n));
        for (int i = 0; i < n && i < log_q.size(); i++) begin
            check($sformatf("%s.data[%0d]", name, i), 32'(log_q[i].data), 32'(base + DW'(i)));
            check($sformatf("%s.last[%0d]", name, i), 32'(log_q[i].last), 32'((i % BL) == BL - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int rd_base;
        int k;

        // Table 1: 8 words preloaded during reset, m_ready high throughout.
        t1[0]  = mk(1, 1, 0, 0, 8'h00, 0, 0);
        t1[1]  = mk(1, 1, 1, 0, 8'h00, 0, 1);
        t1[2]  = mk(1, 1, 1, 0, 8'h00, 0, 1);
        t1[3]  = mk(1, 1, 1, 1, 8'hA0, 0, 1);
        t1[4]  = mk(1, 1, 1, 1, 8'hA1, 0, 1);
        t1[5]  = mk(1, 1, 1, 1, 8'hA2, 0, 1);
        t1[6]  = mk(1, 1, 1, 1, 8'hA3, 1, 1);
        t1[7]  = mk(1, 1, 1, 1, 8'hA4, 0, 1);
        t1[8]  = mk(1, 1, 1, 1, 8'hA5, 0, 1);
        t1[9]  = mk(1, 1, 0, 1, 8'hA6, 0, 1);
        t1[10] = mk(1, 1, 0, 1, 8'hA7, 1, 1);
        t1[11] = mk(1, 1, 0, 0, 8'h00, 0, 1);

        // Table 2: 8 words arrive while running; m_ready is low for 5 cycles mid-stream.
        t2[0]  = mk(1, 1, 0, 0, 8'h00, 0, 1);
        t2[1]  = mk(1, 1, 1, 0, 8'h00, 0, 1);
        t2[2]  = mk(1, 1, 1, 0, 8'h00, 0, 1);
        t2[3]  = mk(1, 1, 1, 1, 8'hC0, 0, 1);
        t2[4]  = mk(1, 0, 0, 1, 8'hC1, 0, 1);
        t2[5]  = mk(1, 0, 0, 1, 8'hC1, 0, 1);
        t2[6]  = mk(1, 0, 0, 1, 8'hC1, 0, 1);
        t2[7]  = mk(1, 0, 0, 1, 8'hC1, 0, 1);
        t2[8]  = mk(1, 0, 0, 1, 8'hC1, 0, 1);
        t2[9]  = mk(1, 1, 1, 1, 8'hC1, 0, 1);
        t2[10] = mk(1, 1, 1, 1, 8'hC2, 0, 1);
        t2[11] = mk(1, 1, 1, 1, 8'hC3, 1, 1);
        t2[12] = mk(1, 1, 1, 1, 8'hC4, 0, 1);
        t2[13] = mk(1, 1, 1, 1, 8'hC5, 0, 1);
        t2[14] = mk(1, 1, 0, 1, 8'hC6, 0, 1);
        t2[15] = mk(1, 1, 0, 1, 8'hC7, 1, 1);
        t2[16] = mk(1, 1, 0, 0, 8'h00, 0, 1);

        // Reset held 3 cycles with enable high and data in the FIFO.
        rst     = 1'b1;
        enable  = 1'b1;
        m_ready = 1'b1;
        push_words(8, 8'hA0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check($sformatf("rst[%0d].fifo_re", i), 32'(fifo_re), 32'd0);
            check($sformatf("rst[%0d].m_valid", i), 32'(m_valid), 32'd0);
            check($sformatf("rst[%0d].m_data", i),  32'(m_data),  32'd0);
            check($sformatf("rst[%0d].m_last", i),  32'(m_last),  32'd0);
            check($sformatf("rst[%0d].busy", i),    32'(busy),    32'd0);
        end
        tick();
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            enable  = t1[i].en;
            m_ready = t1[i].rdy;
            @(negedge clk);
            check_vec("stream", i, t1[i]);
            tick();
        end
`ifdef FIFO_RD_STATS_EN
        check("stats.after8", 32'(word_count), 32'd8);
`endif

        push_words(8, 8'hC0);
        for (int i = 0; i < 17; i++) begin
            enable  = t2[i].en;
            m_ready = t2[i].rdy;
            @(negedge clk);
            check_vec("bp", i, t2[i]);
            tick();
        end
        m_ready = 1'b1;

        // Stop after two reads of a 4-word burst: the burst must still complete.
        log_q.delete();
        rd_base = rd_count;
        push_words(8, 8'hD0);
        tick();
        tick();
        tick();
        enable = 1'b0;
        k = 0;
        @(negedge clk);
        while (busy && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("stop.busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check($sformatf("stop.idle_re[%0d]", i), 32'(fifo_re), 32'd0);
        end
        check("stop.reads", 32'(rd_count - rd_base), 32'd4);
        check_log("stop", 8'hD0, 4);

        // Resume: the remaining words form a complete burst of their own.
        tick();
        log_q.delete();
        enable = 1'b1;
        wait_log("resume", 4, 40);
        check_log("resume", 8'hD4, 4);
        repeat (4) tick();

        // Empty stall: three words now, the fourth ten cycles later.
        log_q.delete();
        push_words(3, 8'hE0);
        repeat (10) tick();
        push_words(1, 8'hE3);
        wait_log("stall", 4, 40);
        check_log("stall", 8'hE0, 4);
        if (log_q.size() >= 4) begin
            check("stall.gap", 32'((log_q[3].cyc - log_q[2].cyc) > 1), 32'd1);
        end

        // Stop at a burst boundary: go straight to idle.
        tick();
        enable = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("boundary.busy", 32'(busy), 32'd0);
        check("boundary.fifo_re", 32'(fifo_re), 32'd0);

        // Reset mid-operation discards the skid and in-flight data.
        tick();
        enable = 1'b1;
        push_words(4, 8'hF0);
        repeat (3) tick();
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check("midrst.fifo_re", 32'(fifo_re), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("midrst[%0d].m_valid", i), 32'(m_valid), 32'd0);
            check($sformatf("midrst[%0d].busy", i),    32'(busy),    32'd0);
            tick();
        end
`ifdef FIFO_RD_STATS_EN
        check("stats.after_rst", 32'(word_count), 32'd0);
`endif

        check("proto.underruns", 32'(underruns), 32'd0);
        check("proto.re_in_rst", 32'(re_in_rst), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fifo_stream_reader

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side engine for the 8x8 synchronous FIFO. It drains the FIFO through its `re`/`r_data`/`empty` port, absorbs the one-cycle FIFO read latency in a 2-entry skid buffer, and presents words on a valid/ready stream with burst framing (`m_last`). It sits between the FIFO read port and any downstream consumer, and never reads an empty FIFO (no underrun).

## Interface
- `DATA_WIDTH`, 8, width of FIFO words and stream data
- `BURST_LEN`, 4, words per burst; `m_last` marks every BURST_LEN-th word; legal range 1..255
- `clk`  in  1  single clock; all logic samples on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `enable`  in  1  level; high starts or continues streaming
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_r_data`  in  DATA_WIDTH  FIFO read data; valid the cycle after `fifo_re` is sampled high
- `fifo_re`  out  1  FIFO read strobe
- `m_valid`  out  1  stream word valid
- `m_data`  out  DATA_WIDTH  stream word
- `m_last`  out  1  last word of a burst; qualified by `m_valid`
- `m_ready`  in  1  downstream accepts the word when `m_valid && m_ready`
- `busy`  out  1  high when state != IDLE, a read is in flight, or the skid is non-empty

## Operation
- FSM states: IDLE, RUN, FINISH.
  - IDLE -> RUN: `enable` = 1.
  - RUN -> IDLE: `enable` = 0 and `req_cnt` = 0 (burst boundary).
  - RUN -> FINISH: `enable` = 0 and `req_cnt` != 0.
  - FINISH -> IDLE: `req_cnt` wraps to 0 (all BURST_LEN reads of the open burst issued). `enable` is ignored in FINISH.
- `req_cnt` counts issued reads modulo BURST_LEN. `beat_cnt` counts accepted output words modulo BURST_LEN.
- `fifo_re` = (state != IDLE) && !`fifo_empty` && (occ + inflight − pop) < 2.
  - `occ` = skid occupancy, 0..2.
  - `inflight` = `fifo_re` registered.
  - pop = `m_valid && m_ready`.
  - This rule guarantees the skid never overflows and gives full throughput.
- Every in-flight word is captured into the skid on arrival, including in IDLE and FINISH.
- Skid is FIFO-ordered. `m_valid` = (occ != 0). `m_data` = head entry.
- `m_last` = (`beat_cnt` == BURST_LEN−1) && `m_valid`.
- `m_data`/`m_last` stay stable while `m_valid && !m_ready`.
- A `fifo_empty` stall mid-burst is legal. The burst continues when data arrives and `m_last` stays aligned to the count.
- With BURST_LEN = 1, every word has `m_last` = 1.

## Timing
- Reset values: `fifo_re` 0, `m_valid` 0, `m_data` 0, `m_last` 0, `busy` 0. State IDLE; `req_cnt`, `beat_cnt`, `occ`, `inflight` all 0.
- `rst` mid-operation discards in-flight and skid data. A FIFO word returned in the cycle after reset is dropped.
- Latency: `fifo_re` high at cycle N -> `fifo_r_data` at N+1 -> `m_valid` at N+2.
- From `enable` rising with a non-empty FIFO: `fifo_re` in the cycle after the IDLE->RUN transition, so first `m_valid` at 3 cycles.
- Throughput: 1 word/cycle with `m_ready` held high and the FIFO non-empty.
- With `m_ready` low, at most 2 words are buffered, then `fifo_re` stays low.

## Configuration
- `FIFO_RD_STATS_EN`: when defined, adds output `word_count` (16 bits).
  - Counts accepted stream words (`m_valid && m_ready`).
  - Wraps at 65535 -> 0. Reset to 0 by `rst`.
- When undefined, the port and counter are absent. All other behaviour is identical.

## Structure
- Package `fifo_rd_pkg`:
  - state enum (IDLE, RUN, FINISH)
  - constant SKID_DEPTH = 2
  - counter width function for BURST_LEN
- Sub-module `fifo_rd_skid`: the 2-entry ordered buffer.
  - Ports: push/data-in, pop, head data, occupancy.
  - Instantiated once.
- FSM, counters and `fifo_re` logic live in `fifo_stream_reader`.

## Test plan
- Reset: hold `rst` 3 cycles with `enable` = 1 and the FIFO holding data -> all outputs 0, `fifo_re` never high during reset.
- Streaming: FIFO preloaded with 8 words, BURST_LEN = 4, `m_ready` = 1, `enable` = 1 -> 8 words in write order on consecutive cycles, `m_last` on words 4 and 8, no `fifo_re` while `fifo_empty`.
- Backpressure: `m_ready` = 0 for 5 cycles mid-stream -> exactly 2 words buffered, `m_data` stable, no loss or duplication after `m_ready` returns.
- Stop mid-burst: drop `enable` after 2 words of a 4-word burst -> 2 more words read, `m_last` on the 4th, then IDLE and `busy` = 0.
- Empty stall: FIFO holds 3 words, 4th written 10 cycles later -> `m_valid` gap, `m_last` on the 4th word, `fifo_re` never asserted while empty.
- Stats (with `FIFO_RD_STATS_EN`): stream 8 words -> `word_count` = 8; reset -> 0.
